clk_edge_monitor: RTL

Fast-domain monitor for a divided or externally sourced slow clock, placed directly downstream of the divider stage. It synchronises the slow clock into the `clk` domain and emits single-cycle rise/fall pulses as clock enables. It also measures the rising-edge-to-rising-edge period in `clk` cycles and reports lock and loss-of-clock status. Downstream logic uses `rise_pulse`/`fall_pulse` as enables instead of clocking flops from the divided clock.

---
 rtl/clk_edge_monitor.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/clk_edge_monitor.sv
// Fast-domain monitor for a slow clock: synchronises clk_in, emits rise/fall
// enable pulses, measures the rise-to-rise period and tracks lock/loss status.
module clk_edge_monitor #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8,
  parameter int TIMEOUT     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_in,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             locked,
  output logic             lost
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2,
    LOST    = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;
  logic                   sync_out;
  logic                   rise;
  logic                   fall;
  logic                   edge_seen;
  logic                   tracking;
  logic                   timeout_hit;
  logic [CNT_W-1:0]       pcnt;
  logic [CNT_W-1:0]       tcnt;
  state_t                 state;
  state_t                 state_next;

  assign sync_out  = sync[SYNC_STAGES-1];
  assign rise      = sync_out & ~prev;
  assign fall      = ~sync_out & prev;
  assign edge_seen = rise | fall;
  assign tracking  = (state == ACQUIRE) || (state == LOCKED);
  // The incrementing tick that would bring tcnt to TIMEOUT; a coincident edge wins.
  assign timeout_hit = tracking && !edge_seen && (tcnt >= TO_LAST);

  // Synchroniser chain and previous-sample flop
  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], clk_in};
      prev <= sync_out;
    end
  end

  // Period counter: restarts at 1 on each rise, saturates at all-ones
  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt <= '0;
    end else if (rise) begin
      pcnt <= CNT_ONE;
    end else if (pcnt != CNT_MAX) begin
      pcnt <= pcnt + CNT_ONE;
    end
  end

  // Timeout counter: only runs while acquiring or locked
  always_ff @(posedge clk) begin
    if (rst) begin
      tcnt <= '0;
    end else if (!tracking || edge_seen) begin
      tcnt <= '0;
    end else if (tcnt < TO_VAL) begin
      tcnt <= tcnt + CNT_ONE;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (rise) state_next = ACQUIRE;
        else      state_next = IDLE;
      end
      ACQUIRE: begin
        if (rise)             state_next = LOCKED;
        else if (timeout_hit) state_next = LOST;
        else                  state_next = ACQUIRE;
      end
      LOCKED: begin
        if (timeout_hit) state_next = LOST;
        else             state_next = LOCKED;
      end
      LOST: begin
        if (rise) state_next = ACQUIRE;
        else      state_next = LOST;
      end
      default: state_next = IDLE;
    endcase
  end

  // Registered outputs, aligned with the state update
  always_ff @(posedge clk) begin
    if (rst) begin
      rise_pulse   <= 1'b0;
      fall_pulse   <= 1'b0;
      period       <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      lost         <= 1'b0;
    end else begin
      rise_pulse   <= rise;
      fall_pulse   <= fall;
      period_valid <= rise && tracking;
      if (rise && tracking) begin
        period <= pcnt;
      end
      locked <= (state_next == LOCKED);
      lost   <= (state_next == LOST);
    end
  end

endmodule
